// File: rtl/dlx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dlx_pkg
// Description : Shared datapath widths, register-file constants and the
//               write-back scheduler state encoding.
// Revision    : 1.0  initial release
// ============================================================================
package dlx_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    DRAIN = 2'd2
  } wb_sched_state_t;

endpackage : dlx_pkg
`default_nettype wire

// File: rtl/wb_sched_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_sched_fifo
// Description : Circular buffer of queued mult/div results. Each entry holds a
//               destination register, data and a live bit that a younger
//               pipeline write to the same register can clear.
// Revision    : 1.0  initial release
// ============================================================================
module wb_sched_fifo
  import dlx_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic [REG_ADDR_W-1:0]   push_rd,
  input  logic [XLEN-1:0]         push_data,
  input  logic                    pop,
  input  logic                    squash_en,
  input  logic [REG_ADDR_W-1:0]   squash_rd,
  output logic                    head_live,
  output logic [REG_ADDR_W-1:0]   head_rd,
  output logic [XLEN-1:0]         head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [REG_ADDR_W-1:0] r_rd   [DEPTH];
  logic [XLEN-1:0]       r_data [DEPTH];
  logic [DEPTH-1:0]      r_live;
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  // Entry storage: a push fills the tail slot; a squash kills older entries with a matching rd.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (r_wptr == AW'(i))) begin
          r_live[i] <= 1'b1;
          r_rd[i]   <= push_rd;
          r_data[i] <= push_data;
        end else if (squash_en && (r_rd[i] == squash_rd)) begin
          r_live[i] <= 1'b0;
        end
      end
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(push) - CW'(pop);
    end
  end

  assign head_live = r_live[r_rptr];
  assign head_rd   = r_rd[r_rptr];
  assign head_data = r_data[r_rptr];
  assign count     = r_count;
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);

endmodule : wb_sched_fifo
`default_nettype wire

// File: rtl/wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_scheduler
// Description : Shares the single register-file write port between the
//               pipeline write-back path (priority) and queued mult/div
//               results. A starved FIFO head forces a one-cycle pipeline
//               stall so it always drains.
//               Optional: WB_SCHED_BYPASS_EN lets a mult/div result go
//               straight to the write port when the slot is free and the
//               FIFO is empty.
// Revision    : 1.0  initial release
// ============================================================================
module wb_port_scheduler
  import dlx_pkg::*;
#(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_rd,
  input  logic [XLEN-1:0]       md_data,
  output logic                  pipe_stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [XLEN-1:0]       rf_wdata
);

  localparam int CW   = $clog2(DEPTH) + 1;
  localparam int AGEW = $clog2(STARVE_LIMIT + 1);

  wb_sched_state_t       r_state;
  wb_sched_state_t       w_state_next;
  logic [AGEW-1:0]       r_age;
  logic [AGEW-1:0]       w_age_next;
  logic [AGEW-1:0]       w_age_inc;

  logic                  w_full;
  logic                  w_empty;
  logic [CW-1:0]         w_count;
  logic [CW-1:0]         w_count_next;
  logic                  w_head_live;
  logic [REG_ADDR_W-1:0] w_head_rd;
  logic [XLEN-1:0]       w_head_data;

  logic                  w_drain;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_wb_take;
  logic                  w_squash_en;

  logic                  w_sel;
  logic                  w_sel_live;
  logic [REG_ADDR_W-1:0] w_sel_rd;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_we_next;

  // ---------------------------------------------------------------------------
  // Handshake and slot arbitration
  // ---------------------------------------------------------------------------
  assign md_ready  = !w_full;
  assign w_drain   = (r_state == DRAIN);
  assign w_wb_take = wb_valid && !w_drain;

`ifdef WB_SCHED_BYPASS_EN
  // Free slot with nothing queued: the mult/div result skips the FIFO.
  assign w_bypass = w_empty && !w_drain && !wb_valid && md_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_push       = md_valid && md_ready && !w_bypass;
  assign w_pop        = w_drain || (!wb_valid && !w_empty);
  assign w_squash_en  = w_wb_take && (wb_rd != REG_ZERO);
  assign w_count_next = w_count + CW'(w_push) - CW'(w_pop);
  assign w_age_inc    = r_age + 1'b1;

  wb_sched_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_rd   (md_rd),
    .push_data (md_data),
    .pop       (w_pop),
    .squash_en (w_squash_en),
    .squash_rd (wb_rd),
    .head_live (w_head_live),
    .head_rd   (w_head_rd),
    .head_data (w_head_data),
    .count     (w_count),
    .full      (w_full),
    .empty     (w_empty)
  );

  // Pick the source that owns this cycle's write slot.
  always_comb begin
    w_sel      = 1'b0;
    w_sel_live = 1'b0;
    w_sel_rd   = '0;
    w_sel_data = '0;
    if (w_pop) begin
      w_sel      = 1'b1;
      w_sel_live = w_head_live;
      w_sel_rd   = w_head_rd;
      w_sel_data = w_head_data;
    end else if (w_wb_take) begin
      w_sel      = 1'b1;
      w_sel_live = 1'b1;
      w_sel_rd   = wb_rd;
      w_sel_data = wb_data;
    end else if (w_bypass) begin
      w_sel      = 1'b1;
      w_sel_live = 1'b1;
      w_sel_rd   = md_rd;
      w_sel_data = md_data;
    end
  end

  // Squashed entries and r0 targets consume their slot but never assert the enable.
  assign w_we_next = w_sel && w_sel_live && (w_sel_rd != REG_ZERO);

  // Registered write port; address and data hold when the slot goes unused.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= w_we_next;
      if (w_sel) begin
        rf_waddr <= w_sel_rd;
        rf_wdata <= w_sel_data;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Starvation FSM and head age counter
  // ---------------------------------------------------------------------------
  // State and age registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_age   <= '0;
    end else begin
      r_state <= w_state_next;
      r_age   <= w_age_next;
    end
  end

  // Next state: age restarts on every pop; reaching the limit forces one drain cycle.
  always_comb begin
    w_state_next = r_state;
    w_age_next   = r_age;
    pipe_stall   = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_age_next = '0;
        if (w_push) w_state_next = PEND;
      end
      PEND: begin
        if (w_pop) begin
          w_age_next   = '0;
          w_state_next = (w_count_next == '0) ? IDLE : PEND;
        end else if (w_age_inc == AGEW'(STARVE_LIMIT)) begin
          w_age_next   = w_age_inc;
          w_state_next = DRAIN;
        end else begin
          w_age_next = w_age_inc;
        end
      end
      DRAIN: begin
        pipe_stall   = 1'b1;
        w_age_next   = '0;
        w_state_next = (w_count_next == '0) ? IDLE : PEND;
      end
      default: begin
        w_age_next   = '0;
        w_state_next = IDLE;
      end
    endcase
  end

endmodule : wb_port_scheduler
`default_nettype wire

// File: tb/tb_wb_port_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_scheduler
// Description : Self-checking bench for wb_port_scheduler: directed scenarios
//               with literal expectations, then randomized traffic against a
//               queue-based behavioural model. Honours WB_SCHED_BYPASS_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_port_scheduler;

  localparam int DEPTH = 2;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        md_valid = 1'b0;
  logic        md_ready;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        pipe_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  always #5 clk = ~clk;

  wb_port_scheduler #(
    .DEPTH        (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .md_valid   (md_valid),
    .md_ready   (md_ready),
    .md_rd      (md_rd),
    .md_data    (md_data),
    .pipe_stall (pipe_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata)
  );

  // Behavioural model: queue of pending results plus how long the head has waited.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          live;
  } ent_t;

  ent_t        q[$];
  int          head_wait = 0;
  bit          exp_we = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_data = '0;
  bit          cur_stall = 1'b0;
  bit          cur_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic drive(input bit wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input bit mv, input logic [4:0] mrd, input logic [31:0] md);
    wb_valid = wv; wb_rd = wrd; wb_data = wd;
    md_valid = mv; md_rd = mrd; md_data = md;
  endtask

  // Apply this cycle's inputs to the model and predict the write port after the edge.
  task automatic model_step();
    bit   push;
    bit   pop;
    ent_t h;
    ent_t n;
    cur_stall = (q.size() > 0) && (head_wait >= LIMIT);
    cur_ready = (q.size() < DEPTH);
    push   = md_valid && cur_ready;
    pop    = 1'b0;
    exp_we = 1'b0;
    if (cur_stall) begin
      pop = 1'b1;
    end else if (wb_valid) begin
      exp_we   = (wb_rd != 5'd0);
      exp_addr = wb_rd;
      exp_data = wb_data;
      if (wb_rd != 5'd0)
        foreach (q[i]) if (q[i].rd == wb_rd) q[i].live = 1'b0;
    end
`ifdef WB_SCHED_BYPASS_EN
    else if (q.size() == 0 && md_valid) begin
      exp_we   = (md_rd != 5'd0);
      exp_addr = md_rd;
      exp_data = md_data;
      push     = 1'b0;
    end
`endif
    else if (q.size() > 0) begin
      pop = 1'b1;
    end
    if (pop) begin
      h         = q.pop_front();
      exp_we    = h.live && (h.rd != 5'd0);
      exp_addr  = h.rd;
      exp_data  = h.data;
      head_wait = 0;
    end else if (q.size() > 0) begin
      head_wait++;
    end
    if (push) begin
      n.rd = md_rd; n.data = md_data; n.live = 1'b1;
      q.push_back(n);
    end
  endtask

  // One clock: predict, let the edge happen, compare everything shortly after it.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, exp_we);
    if (exp_we) begin
      chk("rf_waddr", rf_waddr, exp_addr);
      chk("rf_wdata", rf_wdata, exp_data);
    end
    chk("pipe_stall", pipe_stall, (q.size() > 0) && (head_wait >= LIMIT));
    chk("md_ready", md_ready, q.size() < DEPTH);
  endtask

  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk("reset rf_we", rf_we, 0);
    chk("reset rf_waddr", rf_waddr, 0);
    chk("reset rf_wdata", rf_wdata, 0);
    chk("reset pipe_stall", pipe_stall, 0);
    chk("reset md_ready", md_ready, 1);
    q.delete();
    head_wait = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [4:0] pick_rd();
    if ($urandom_range(0, 9) < 8) return 5'($urandom_range(0, 4));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    int n;
    bit hold_wb;
    bit hold_md;
    #2;
    apply_reset();

    // Pipeline-only write lands one cycle later.
    drive(1, 5'd7, 32'hDEADBEEF, 0, 0, 0);
    cycle();
    chk("pipe_only we", rf_we, 1);
    chk("pipe_only addr", rf_waddr, 7);
    chk("pipe_only data", rf_wdata, 32'hDEADBEEF);
    chk("pipe_only stall", pipe_stall, 0);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("idle we", rf_we, 0);

    // Mult/div result drains into an idle slot.
    drive(0, 0, 0, 1, 5'd3, 32'h12);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
`ifdef WB_SCHED_BYPASS_EN
    chk("bypass t+1 we", rf_we, 1);
    chk("bypass t+1 addr", rf_waddr, 3);
    chk("bypass t+1 data", rf_wdata, 32'h12);
    cycle();
`else
    chk("drain t+1 we", rf_we, 0);
    cycle();
    chk("drain t+2 we", rf_we, 1);
    chk("drain t+2 addr", rf_waddr, 3);
    chk("drain t+2 data", rf_wdata, 32'h12);
`endif
    cycle();

    // Starvation: head waits LIMIT cycles, one stall cycle, then the held write lands.
    drive(0, 0, 0, 1, 5'd4, 32'h44);
    cycle();
    for (int k = 1; k <= 4; k++) begin
      drive(1, 5'd10, 32'h1000 + 32'(k), 0, 0, 0);
      cycle();
      chk("starve stall", pipe_stall, 32'(k == 4));
    end
    drive(1, 5'd10, 32'h1005, 0, 0, 0);
    cycle();
    chk("starve md we", rf_we, 1);
    chk("starve md addr", rf_waddr, 4);
    chk("starve md data", rf_wdata, 32'h44);
    chk("starve released", pipe_stall, 0);
    cycle();
    chk("starve held addr", rf_waddr, 10);
    chk("starve held data", rf_wdata, 32'h1005);
    drive(0, 0, 0, 0, 0, 0);
    cycle();

    // WAW squash: younger pipeline write to rd 9 kills the queued one.
    drive(1, 5'd5, 32'h1, 1, 5'd9, 32'hAA);
    cycle();
    drive(1, 5'd9, 32'hBB, 0, 0, 0);
    cycle();
    chk("waw pipe addr", rf_waddr, 9);
    chk("waw pipe data", rf_wdata, 32'hBB);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("waw squashed we", rf_we, 0);
    chk("waw empty ready", md_ready, 1);
    cycle();

    // Full FIFO: md_ready low until the starved head is forced out.
    drive(1, 5'd6, 32'h600, 1, 5'd11, 32'h111);
    cycle();
    drive(1, 5'd6, 32'h601, 1, 5'd12, 32'h222);
    cycle();
    chk("full ready", md_ready, 0);
    drive(1, 5'd6, 32'h602, 1, 5'd13, 32'h333);
    n = 0;
    while (md_ready !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    chk("full wait cycles", 32'(n), 4);
    cycle();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) cycle();

    // r0 result consumes its slot without a write.
    drive(1, 5'd5, 32'h55, 1, 5'd0, 32'h77);
    cycle();
    chk("r0 pipe we", rf_we, 1);
    drive(0, 0, 0, 0, 0, 0);
    cycle();
    chk("r0 pop we", rf_we, 0);
    cycle();

    // Reset while draining with two entries queued.
    drive(1, 5'd6, 32'h700, 1, 5'd14, 32'hE0);
    cycle();
    drive(1, 5'd6, 32'h701, 1, 5'd15, 32'hF0);
    cycle();
    drive(1, 5'd6, 32'h702, 0, 0, 0);
    n = 0;
    while (pipe_stall !== 1'b1 && n < 10) begin
      cycle();
      n++;
    end
    chk("pre-reset drain", pipe_stall, 1);
    chk("pre-reset full", md_ready, 0);
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("post-reset no write", rf_we, 0);
    end

    // Randomized traffic; the pipeline holds while stalled, mult/div holds while not ready.
    hold_wb = 1'b0;
    hold_md = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold_wb) begin
        wb_valid = ($urandom_range(0, 99) < ((c < 1500) ? 85 : 50));
        wb_rd    = pick_rd();
        wb_data  = $urandom();
      end
      if (!hold_md) begin
        md_valid = ($urandom_range(0, 99) < 40);
        md_rd    = pick_rd();
        md_data  = $urandom();
      end
      cycle();
      hold_wb = wb_valid && cur_stall;
      hold_md = md_valid && !cur_ready;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule : tb_wb_port_scheduler
`default_nettype wire

// File: doc/wb_port_scheduler.md
# wb_port_scheduler

Arbitrates the single register-file write port between the in-order pipeline write-back path and the multi-cycle multiply/divide unit. Pipeline results have priority. Mult/div results wait in a small FIFO and drain into idle write-back slots. A starvation limit forces a pipeline stall so that queued results always drain. The block sits between the write-back mux output and the register file write port.

## Interface
Parameters:
- DEPTH, 2, mult/div result FIFO entries (power of two, ≥2)
- STARVE_LIMIT, 4, cycles a FIFO head may wait before a forced drain (≥1)

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- wb_valid  input  1  pipeline write-back has a result this cycle
- wb_rd  input  5  pipeline destination register
- wb_data  input  32  pipeline write-back value
- md_valid  input  1  mult/div result offered
- md_ready  output  1  FIFO can accept (= !full)
- md_rd  input  5  mult/div destination register
- md_data  input  32  mult/div result
- pipe_stall  output  1  pipeline must hold its write-back instruction
- rf_we  output  1  register-file write enable (registered)
- rf_waddr  output  5  register-file write address (registered)
- rf_wdata  output  32  register-file write data (registered)

## Operation
- Mult/div handshake: transfer when md_valid && md_ready. md_ready depends only on the current count. A pop in the same cycle does not allow a push into a full FIFO.
- Per-cycle selection, registered onto rf_*:
  - In DRAIN: pop the FIFO head. Ignore wb_valid; the pipeline holds.
  - Else if wb_valid: write the pipeline result.
  - Else if the FIFO is non-empty: pop the head.
  - Else: rf_we=0. rf_waddr and rf_wdata hold their previous values.
- Register r0: any selected write with rd==0 is consumed normally, but rf_we stays 0.
- WAW squash:
  - When a pipeline write with rd≠0 is accepted, clear the valid bit of every FIFO entry with the same rd.
  - The pipeline write is younger, so the queued result is dead.
  - A squashed entry is popped silently, with rf_we=0 and no cycle charged beyond its slot.
  - A result pushed in the same cycle is not squashed.
- Age counter: counts cycles the current head has waited without being popped. It resets to 0 on every pop and on any change of head.
- States:
  - IDLE: FIFO empty.
  - PEND: non-empty and age < STARVE_LIMIT.
  - DRAIN: age reached STARVE_LIMIT.
- Transitions:
  - IDLE→PEND on push.
  - PEND→DRAIN when age increments to STARVE_LIMIT.
  - PEND→IDLE when the last entry pops.
  - DRAIN→PEND or DRAIN→IDLE after the head pops, depending on the remaining count.
- pipe_stall = (state==DRAIN). It is a combinational decode of registered state.

## Timing
- Pipeline write accepted in cycle t: rf_we high in cycle t+1.
- Mult/div result pushed in cycle t: earliest rf_we in cycle t+2.
- DRAIN lasts exactly one cycle per starved head.
- Worst-case wait for a FIFO head: STARVE_LIMIT+1 cycles.
- Reset values, asynchronous on rst_n low:
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - FIFO empty, age=0, state IDLE.
  - pipe_stall=0, md_ready=1.
- Reset mid-operation discards all queued results; no write is issued for them.
- Full FIFO: md_ready=0. The mult/div unit holds md_valid and its data stable.

## Configuration
- WB_SCHED_BYPASS_EN defined:
  - Applies when the FIFO is empty, the state is not DRAIN, wb_valid=0 and md_valid=1.
  - The mult/div result goes directly to rf_* without entering the FIFO. md_ready stays 1.
  - Latency becomes t+1.
- Undefined: every mult/div result goes through the FIFO, with latency t+2 minimum.

## Structure
- Shared package dlx_pkg holds:
  - XLEN=32, REG_ADDR_W=5, REG_ZERO=5'd0
  - the wb_sched_state_t enum (IDLE, PEND, DRAIN)
- Sub-module wb_sched_fifo: circular buffer with per-entry valid and rd. It has push, pop, rd-match squash input, head outputs, count/full/empty.
- The top level holds arbitration, age counter, FSM and output registers.

## Test plan
- Pipeline-only:
  - Stimulus: wb_valid=1, wb_rd=7, wb_data=0xDEADBEEF at t.
  - Response: at t+1, rf_we=1, rf_waddr=7, rf_wdata=0xDEADBEEF. No stall.
- Idle-slot drain:
  - Stimulus: md push rd=3, data=0x12 at t, wb_valid=0 throughout.
  - Response without macro: rf_we=1, rf_waddr=3 at t+2. With WB_SCHED_BYPASS_EN: the same write at t+1.
- Starvation:
  - Stimulus: md push rd=4, then wb_valid=1 continuously.
  - Response: pipe_stall=1 exactly one cycle after the head has waited 4 cycles. rd=4 is written in the next cycle. The held pipeline write lands in the cycle after that.
- WAW squash:
  - Stimulus: queue rd=9, data=0xAA, then a pipeline write rd=9, data=0xBB.
  - Response: the only rf write to 9 is 0xBB. The queued entry is popped with rf_we=0.
- Full and r0:
  - Stimulus: push 2 entries with wb_valid=1 held, then a third md_valid. Separately, an md result with rd=0.
  - Response: md_ready=0 until the first pop. The rd=0 result pops with rf_we=0.
- Reset mid-operation:
  - Stimulus: rst_n low with 2 entries queued in DRAIN.
  - Response: immediately rf_we=0, pipe_stall=0, md_ready=1. No queued write appears after release.
